case_2_mul_arbiter: RTL
=======================

# case_2_mul_arbiter

Round-robin arbiter sharing one 5x5-bit unsigned multiplier core among NUM_REQ requesters in the case_2 datapath. Accepts one operand pair per cycle over per-requester valid/ready, returns each truncated product tagged by requester ID two cycles later, and stalls cleanly under response backpressure. Sits between the case_2 requesting loops and the single `case_2_mul_5ns_5ns_6_1_1` instance.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: requester-ID width, equal to clog2(NUM_REQ).
- DIN0_WIDTH, 5: operand A width.
- DIN1_WIDTH, 5: operand B width.
- DOUT_WIDTH, 6: product width after truncation.
- CNT_W, 16: width of the completed-operation counter.
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_din0  in  NUM_REQ*DIN0_WIDTH  operand A; requester i occupies slice i.
- req_din1  in  NUM_REQ*DIN1_WIDTH  operand B; requester i occupies slice i.
- rsp_valid  out  1  result valid.
- rsp_id  out  ID_W  requester owning the result.
- rsp_dout  out  DOUT_WIDTH  product.
- rsp_ready  in  1  result consumer accept.
- ops_done  out  CNT_W  saturating count of delivered results.

## Operation
- Accept: `req_valid[i] & req_ready[i]`.
- Delivery: `rsp_valid & rsp_ready`.
- Stage 1, operand register: op_valid, op_id, op_a, op_b.
  - Loads on accept.
  - Advances when stage 2 can load.
- Stage 2, result register: res_valid, res_id, res_dout.
  - Loads when `!res_valid | rsp_ready`.
  - Load value is the multiplier output for the stage-1 operands.
- Arithmetic: rsp_dout = (din0 × din1) mod 2^DOUT_WIDTH, both operands unsigned, zero-extended. Full product is not preserved.
- Arbitration:
  - rr_ptr holds the last granted ID.
  - Search order starts at rr_ptr+1 and wraps at NUM_REQ-1 → 0.
  - The grant goes to the first valid requester in that order.
  - req_ready[g] = 1 only for the granted g, and only when `!op_valid | stage-1 advancing`.
- rr_ptr updates only on accept. A requester dropping valid does not move it.
- req_ready depends combinationally on req_valid. Requesters must not make valid depend on ready.
- Requester obligation: after raising valid, hold valid and operands stable until accepted.
- ops_done: increments on each delivery and saturates at 2^CNT_W-1.
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_dout=0, ops_done=0, op_valid=0, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation discards in-flight operands and results. No response is produced for them.

## Timing
- Latency: accept at edge N → rsp_valid high after edge N+2, with rsp_ready held high.
- Throughput: one accept per cycle sustained while rsp_ready=1.
- Backpressure, with rsp_ready low:
  - Stage 2 holds its contents.
  - Stage 1 fills once, then all req_ready go low.
  - Maximum in flight is 2 operations.
- When rsp_ready rises, both stages drain and accepts resume in the same cycle.
- Simultaneous stage-1 advance and new accept in one cycle is allowed. The new operand replaces the advancing one.
- Outputs are registered except req_ready.

## Structure
- Package `case_2_mul_arb_pkg` holds:
  - NUM_REQ, ID_W, DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH defaults.
  - Function rr_pick(valid, ptr), returning the grant ID and a found flag.
- Sub-module: one instance of `case_2_mul_5ns_5ns_6_1_1` between stage 1 and stage 2 (combinational, NUM_STAGE=0).
- Arbiter, stage control and counter live in this module.

## Test plan
- Single op: requester 2 sends 5,7 → req_ready[2] same cycle; rsp_valid two cycles later with rsp_id=2, rsp_dout=35; ops_done=1.
- Truncation: 31×31 → rsp_dout=1. 3×30 → 26. 0×31 → 0.
- Fairness: all 4 requesters valid continuously → grant order 0,1,2,3,0,1,… starting from reset; four results per four cycles.
- Backpressure: rsp_ready=0 for 5 cycles with all requesters valid → exactly 2 accepts, then req_ready=0. On rsp_ready=1, results come out in accept order with correct IDs; no loss or duplication.
- Reset mid-flight: ap_rst_n low while 2 ops in flight → rsp_valid=0 immediately (asynchronous), ops_done=0, rr_ptr=3. After release, first grant goes to requester 0.
- Saturation: CNT_W=4, 20 deliveries → ops_done holds 15.

Source files
------------

// File: rtl/case_2_mul_arb_pkg.sv
// Shared defaults and the round-robin pick helper for the case_2 multiplier arbiter.
package case_2_mul_arb_pkg;

  localparam int unsigned DefNumReq    = 4;
  localparam int unsigned DefIdW       = 2;
  localparam int unsigned DefDin0Width = 5;
  localparam int unsigned DefDin1Width = 5;
  localparam int unsigned DefDoutWidth = 6;

  // The pick helper is sized for the largest supported requester count.
  localparam int unsigned MaxReq = 8;
  localparam int unsigned MaxIdW = 3;

  typedef struct packed {
    logic              found;
    logic [MaxIdW-1:0] id;
  } rr_pick_t;

  // First valid requester after ptr, wrapping at num_req-1 back to 0.
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                       input logic [MaxIdW-1:0] ptr,
                                       input int unsigned       num_req);
    rr_pick_t          res;
    logic [MaxIdW-1:0] idx;
    res = '0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      idx = MaxIdW'((32'(ptr) + k) % num_req);
      if (k <= num_req && !res.found && valid[idx]) begin
        res.found = 1'b1;
        res.id    = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/case_2_mul_5ns_5ns_6_1_1.sv
// Combinational unsigned multiplier keeping only the low DOUT_WIDTH product bits.
module case_2_mul_5ns_5ns_6_1_1 #(
  parameter int unsigned DIN0_WIDTH = 5,
  parameter int unsigned DIN1_WIDTH = 5,
  parameter int unsigned DOUT_WIDTH = 6
) (
  input  logic [DIN0_WIDTH-1:0] din0_i,
  input  logic [DIN1_WIDTH-1:0] din1_i,
  output logic [DOUT_WIDTH-1:0] dout_o
);

  // Low product bits depend only on low operand bits, so multiply at output width.
  assign dout_o = DOUT_WIDTH'(din0_i) * DOUT_WIDTH'(din1_i);

endmodule

// File: rtl/case_2_mul_arbiter.sv
// Round-robin arbiter feeding one shared multiplier through a two-stage
// operand/result pipeline with response backpressure.
module case_2_mul_arbiter
  import case_2_mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DefNumReq,
  parameter int unsigned ID_W       = DefIdW,
  parameter int unsigned DIN0_WIDTH = DefDin0Width,
  parameter int unsigned DIN1_WIDTH = DefDin1Width,
  parameter int unsigned DOUT_WIDTH = DefDoutWidth,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DOUT_WIDTH-1:0]         rsp_dout,
  input  logic                          rsp_ready,
  output logic [CNT_W-1:0]              ops_done
);

  logic                  op_valid_q, op_valid_d;
  logic [ID_W-1:0]       op_id_q, op_id_d;
  logic [DIN0_WIDTH-1:0] op_a_q, op_a_d;
  logic [DIN1_WIDTH-1:0] op_b_q, op_b_d;

  logic                  res_valid_q, res_valid_d;
  logic [ID_W-1:0]       res_id_q, res_id_d;
  logic [DOUT_WIDTH-1:0] res_dout_q, res_dout_d;

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      ops_done_q, ops_done_d;

  rr_pick_t              pick;
  logic [ID_W-1:0]       grant_id;
  logic                  s2_load, s1_adv, s1_free, accept, deliver;
  logic [DOUT_WIDTH-1:0] mul_dout;

  case_2_mul_5ns_5ns_6_1_1 #(
    .DIN0_WIDTH(DIN0_WIDTH),
    .DIN1_WIDTH(DIN1_WIDTH),
    .DOUT_WIDTH(DOUT_WIDTH)
  ) u_mul (
    .din0_i(op_a_q),
    .din1_i(op_b_q),
    .dout_o(mul_dout)
  );

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick = rr_pick(MaxReq'(req_valid), MaxIdW'(rr_ptr_q), NUM_REQ);
  end

  assign grant_id = ID_W'(pick.id);
  assign s2_load  = !res_valid_q || rsp_ready;
  assign s1_adv   = op_valid_q && s2_load;
  assign s1_free  = !op_valid_q || s1_adv;
  // Gated by reset so no requester sees a grant while the pipeline is held.
  assign accept   = pick.found && s1_free && ap_rst_n;
  assign deliver  = res_valid_q && rsp_ready;

  // One-hot ready for the granted requester only.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Next-state for both pipeline stages, pointer and delivery counter.
  always_comb begin
    op_valid_d  = op_valid_q;
    op_id_d     = op_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_dout_d  = res_dout_q;
    rr_ptr_d    = rr_ptr_q;
    ops_done_d  = ops_done_q;

    if (s1_adv) begin
      op_valid_d = 1'b0;
    end
    // A new accept overrides the advancing operand in the same cycle.
    if (accept) begin
      op_valid_d = 1'b1;
      op_id_d    = grant_id;
      op_a_d     = req_din0[grant_id*DIN0_WIDTH +: DIN0_WIDTH];
      op_b_d     = req_din1[grant_id*DIN1_WIDTH +: DIN1_WIDTH];
      rr_ptr_d   = grant_id;
    end

    if (s2_load) begin
      res_valid_d = op_valid_q;
      // Keep stale payload when nothing moves in, so outputs only change with data.
      if (op_valid_q) begin
        res_id_d   = op_id_q;
        res_dout_d = mul_dout;
      end
    end

    if (deliver && (ops_done_q != {CNT_W{1'b1}})) begin
      ops_done_d = ops_done_q + CNT_W'(1);
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      op_valid_q  <= 1'b0;
      op_id_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_dout_q  <= '0;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      ops_done_q  <= '0;
    end else begin
      op_valid_q  <= op_valid_d;
      op_id_q     <= op_id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_dout_q  <= res_dout_d;
      rr_ptr_q    <= rr_ptr_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign rsp_valid = res_valid_q;
  assign rsp_id    = res_id_q;
  assign rsp_dout  = res_dout_q;
  assign ops_done  = ops_done_q;

endmodule
